id_ex_stage: RTL

- Pipeline register between decode (register-file read) and execute.
- Captures RF read data, decoded control and immediate each cycle.
- Detects load-use hazards and inserts one bubble.
- Resolves EX/MEM and MEM/WB forwarding on the registered operands, so execute receives final operands.

---
 rtl/id_ex_stage_pkg.sv | 45 ++++
 rtl/id_ex_stage_fwd_mux.sv | 29 ++
 rtl/id_ex_stage.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared widths, forward-select codes, ALU opcodes and the execute-slot record for the ID/EX stage.
package id_ex_stage_pkg;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int OPW = 4;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_EXM = 2'b10;

    typedef enum logic [OPW-1:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLT = 4'd5,
        ALU_SLL = 4'd6,
        ALU_SRL = 4'd7,
        ALU_SRA = 4'd8,
        ALU_LUI = 4'd9
    } alu_op_e;

    typedef struct packed {
        logic           valid;
        logic           rfwe;
        logic           memrd;
        logic           memwr;
        logic           alusrc;
        logic [OPW-1:0] aluop;
        logic [AW-1:0]  rfwa;
        logic [AW-1:0]  ra1;
        logic [AW-1:0]  ra2;
        logic [DW-1:0]  imm;
        logic [DW-1:0]  opa;
        logic [DW-1:0]  opb;
    } ex_slot_t;

    // A writer hits a source only if it writes, targets that source, and the target is not r0.
    function automatic logic reg_hit(input logic we, input logic [AW-1:0] wa, input logic [AW-1:0] ra);
        return we && (wa != '0) && (wa == ra);
    endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding select for one execute source: EX/MEM beats writeback beats the stored RF value.
module fwd_mux
    import id_ex_stage_pkg::*;
(
    input  logic [AW-1:0] src_addr,
    input  logic          exm_we,
    input  logic [AW-1:0] exm_wa,
    input  logic [DW-1:0] exm_wd,
    input  logic          wb_we,
    input  logic [AW-1:0] wb_wa,
    input  logic [DW-1:0] wb_wd,
    input  logic [DW-1:0] stored,
    output logic [1:0]    sel,
    output logic [DW-1:0] operand
);

    always_comb begin
        sel     = FWD_RF;
        operand = stored;
        if (reg_hit(exm_we, exm_wa, src_addr)) begin
            sel     = FWD_EXM;
            operand = exm_wd;
        end else if (reg_hit(wb_we, wb_wa, src_addr)) begin
            sel     = FWD_WB;
            operand = wb_wd;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and EX/MEM, MEM/WB operand forwarding.
// Optional stall counter output STALLCNT is enabled by defining ID_EX_STALL_CNT_EN.
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           DVALID,
    input  logic [AW-1:0]  RFRA1,
    input  logic [AW-1:0]  RFRA2,
    input  logic [DW-1:0]  RFRD1D,
    input  logic [DW-1:0]  RFRD2D,
    input  logic [AW-1:0]  DWA,
    input  logic           DRFWE,
    input  logic           DMEMRD,
    input  logic           DMEMWR,
    input  logic           DALUSRC,
    input  logic [OPW-1:0] DALUOP,
    input  logic [DW-1:0]  DIMM,
    input  logic           FLUSHE,
    input  logic           HOLDE,
    input  logic           EXM_RFWE,
    input  logic [AW-1:0]  EXM_RFWA,
    input  logic [DW-1:0]  EXM_ALUOUT,
    input  logic           WB_RFWE,
    input  logic [AW-1:0]  WB_RFWA,
    input  logic [DW-1:0]  WB_RFWD,
`ifdef ID_EX_STALL_CNT_EN
    output logic [31:0]    STALLCNT,
`endif
    output logic           STALLD,
    output logic           EVALID,
    output logic           ERFWE,
    output logic           EMEMRD,
    output logic           EMEMWR,
    output logic           EALUSRC,
    output logic [OPW-1:0] EALUOP,
    output logic [AW-1:0]  ERFWA,
    output logic [AW-1:0]  ERA1,
    output logic [AW-1:0]  ERA2,
    output logic [DW-1:0]  EIMM,
    output logic [DW-1:0]  OPAE,
    output logic [DW-1:0]  OPBE,
    output logic [1:0]     FWDAE,
    output logic [1:0]     FWDBE
);

    ex_slot_t slot_q, slot_d;
    logic     luh;

    assign luh = slot_q.valid && slot_q.memrd && DVALID && (slot_q.rfwa != '0) &&
                 ((slot_q.rfwa == RFRA1) || (slot_q.rfwa == RFRA2));

    assign STALLD = luh || HOLDE;

    // Controls are gated by DVALID on capture, so an invalid slot never presents live controls.
    always_comb begin
        slot_d = slot_q;
        if (FLUSHE) begin
            slot_d = '0;
        end else if (HOLDE) begin
            slot_d = slot_q;
        end else if (luh) begin
            slot_d = '0;
        end else begin
            slot_d.valid  = DVALID;
            slot_d.rfwe   = DRFWE && DVALID;
            slot_d.memrd  = DMEMRD && DVALID;
            slot_d.memwr  = DMEMWR && DVALID;
            slot_d.alusrc = DALUSRC && DVALID;
            slot_d.aluop  = DALUOP;
            slot_d.rfwa   = DWA;
            slot_d.ra1    = RFRA1;
            slot_d.ra2    = RFRA2;
            slot_d.imm    = DIMM;
            slot_d.opa    = RFRD1D;
            slot_d.opb    = RFRD2D;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    fwd_mux u_fwd_a (
        .src_addr (slot_q.ra1),
        .exm_we   (EXM_RFWE),
        .exm_wa   (EXM_RFWA),
        .exm_wd   (EXM_ALUOUT),
        .wb_we    (WB_RFWE),
        .wb_wa    (WB_RFWA),
        .wb_wd    (WB_RFWD),
        .stored   (slot_q.opa),
        .sel      (FWDAE),
        .operand  (OPAE)
    );

    fwd_mux u_fwd_b (
        .src_addr (slot_q.ra2),
        .exm_we   (EXM_RFWE),
        .exm_wa   (EXM_RFWA),
        .exm_wd   (EXM_ALUOUT),
        .wb_we    (WB_RFWE),
        .wb_wa    (WB_RFWA),
        .wb_wd    (WB_RFWD),
        .stored   (slot_q.opb),
        .sel      (FWDBE),
        .operand  (OPBE)
    );

    assign EVALID  = slot_q.valid;
    assign ERFWE   = slot_q.rfwe;
    assign EMEMRD  = slot_q.memrd;
    assign EMEMWR  = slot_q.memwr;
    assign EALUSRC = slot_q.alusrc;
    assign EALUOP  = slot_q.aluop;
    assign ERFWA   = slot_q.rfwa;
    assign ERA1    = slot_q.ra1;
    assign ERA2    = slot_q.ra2;
    assign EIMM    = slot_q.imm;

`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Counts every edge that holds decode for a load-use hazard, unless execute is being flushed.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (luh && !FLUSHE) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign STALLCNT = stall_cnt_q;
`endif

endmodule
